// File: rtl/rgb_fade_sequencer.sv
// Keyframe colour sequencer feeding the rgb_mixer PWM duty levels: ramps each channel
// one LSB per step tick toward the current keyframe, holds, then advances through the table.
module rgb_fade_sequencer #(
  parameter int NUM_KEYS = 4,
  parameter int DIV_W    = 16,
  parameter int HOLD_W   = 16,
  parameter int KW       = $clog2(NUM_KEYS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [23:0]   cfg_wdata,
  input  logic          run,
  input  logic          manual_sel,
  input  logic [7:0]    manual_r,
  input  logic [7:0]    manual_g,
  input  logic [7:0]    manual_b,
  output logic [7:0]    level_r,
  output logic [7:0]    level_g,
  output logic [7:0]    level_b,
  output logic [KW-1:0] key_idx,
  output logic          busy,
  output logic          arrive
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_DIV  = 3'd4;
  localparam logic [2:0] ADDR_HOLD = 3'd5;
  localparam logic [2:0] ADDR_LAST = 3'd6;

  state_t            state_q, state_d;
  logic [23:0]       key_q [NUM_KEYS];
  logic [23:0]       key_d [NUM_KEYS];
  logic [DIV_W-1:0]  step_div_q, step_div_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [KW-1:0]     last_key_q, last_key_d;
  logic [KW-1:0]     key_idx_q, key_idx_d;
  logic [23:0]       lvl_q, lvl_d;
  logic              busy_q, busy_d;
  logic              arrive_q, arrive_d;

  logic              run_eff_s;
  logic              tick_s;
  logic              div_wr_s;
  logic [23:0]       tgt_s;
  logic [23:0]       stepped_s;

  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] res;
    if (cur < tgt) begin
      res = cur + 8'd1;
    end else if (cur > tgt) begin
      res = cur - 8'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Config port decode: keyframe table, step divider, hold length and last key
  always_comb begin
    key_d      = key_q;
    step_div_d = step_div_q;
    hold_d     = hold_q;
    last_key_d = last_key_q;
    div_wr_s   = 1'b0;
    if (cfg_we) begin
      if ({1'b0, cfg_addr} < 4'(NUM_KEYS)) begin
        key_d[cfg_addr[KW-1:0]] = cfg_wdata;
      end else begin
        case (cfg_addr)
          ADDR_DIV: begin
            step_div_d = cfg_wdata[DIV_W-1:0];
            div_wr_s   = 1'b1;
          end
          ADDR_HOLD: hold_d     = cfg_wdata[HOLD_W-1:0];
          ADDR_LAST: last_key_d = cfg_wdata[KW-1:0];
          default:   div_wr_s   = 1'b0;
        endcase
      end
    end else begin
      div_wr_s = 1'b0;
    end
  end

  // Sequencer next state, step-tick divider, level ramp and hold/advance control
  always_comb begin
    run_eff_s  = run & ~manual_sel;
    tgt_s      = key_q[key_idx_q];
    tick_s     = (state_q != S_IDLE) && (div_cnt_q == step_div_q);
    stepped_s  = tick_s ? {step_toward(lvl_q[23:16], tgt_s[23:16]),
                           step_toward(lvl_q[15:8],  tgt_s[15:8]),
                           step_toward(lvl_q[7:0],   tgt_s[7:0])} : lvl_q;
    state_d    = state_q;
    lvl_d      = lvl_q;
    key_idx_d  = key_idx_q;
    hold_cnt_d = hold_cnt_q;
    arrive_d   = 1'b0;

    if ((state_q == S_IDLE) || tick_s || div_wr_s) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (run_eff_s) begin
          state_d = S_RAMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RAMP: begin
        if (!run_eff_s) begin
          state_d = S_IDLE;
        end else begin
          lvl_d = stepped_s;
          // Compare against the post-step level so arrive lines up with the final step
          if (stepped_s == tgt_s) begin
            state_d    = S_HOLD;
            arrive_d   = 1'b1;
            hold_cnt_d = hold_q;
          end else begin
            state_d = S_RAMP;
          end
        end
      end
      S_HOLD: begin
        if (!run_eff_s) begin
          state_d = S_IDLE;
        end else if (!tick_s) begin
          state_d = S_HOLD;
        end else if (hold_cnt_q == '0) begin
          state_d   = S_RAMP;
          key_idx_d = (key_idx_q >= last_key_q) ? '0 : key_idx_q + KW'(1);
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Manual mode owns the levels; the sequencer later resumes from whatever is shown
    if (manual_sel) begin
      lvl_d = {manual_r, manual_g, manual_b};
    end else begin
      lvl_d = lvl_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_q[i] <= 24'd0;
      end
      step_div_q <= '0;
      div_cnt_q  <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      last_key_q <= KW'(NUM_KEYS - 1);
      key_idx_q  <= '0;
      lvl_q      <= 24'd0;
      busy_q     <= 1'b0;
      arrive_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      step_div_q <= step_div_d;
      div_cnt_q  <= div_cnt_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      last_key_q <= last_key_d;
      key_idx_q  <= key_idx_d;
      lvl_q      <= lvl_d;
      busy_q     <= busy_d;
      arrive_q   <= arrive_d;
    end
  end

  assign level_r = lvl_q[23:16];
  assign level_g = lvl_q[15:8];
  assign level_b = lvl_q[7:0];
  assign key_idx = key_idx_q;
  assign busy    = busy_q;
  assign arrive  = arrive_q;

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
Colour-sequence controller that drives the three 8-bit duty levels consumed by the rgb_mixer PWM stage. It holds a small keyframe table written over a simple config port (driven from LA bits by the CPU). It ramps each channel one LSB per step tick toward the current keyframe, holds, then advances, looping through the table. A manual-select input hands the PWM levels back to the encoder counters; the sequencer freezes while manual is selected.

Parameters:
NUM_KEYS, 4, keyframe table depth (power of two; index width KW = log2(NUM_KEYS))
DIV_W, 16, width of the step-tick divider register
HOLD_W, 16, width of the hold-count register

Ports:
clk  input  1  system clock (wb_clk_i at wrapper level)
reset  input  1  asynchronous, active-high reset
cfg_we  input  1  config write strobe, one write per cycle high
cfg_addr  input  3  0..NUM_KEYS-1 keyframe; 4 step_div; 5 hold; 6 last_key
cfg_wdata  input  24  keyframe {r[23:16],g[15:8],b[7:0]}; step_div/hold in [DIV_W-1:0]/[HOLD_W-1:0]; last_key in [KW-1:0]
run  input  1  1 = sequence active
manual_sel  input  1  1 = outputs follow manual_r/g/b
manual_r, manual_g, manual_b  input  8 each  encoder-counter levels
level_r, level_g, level_b  output  8 each  registered duty levels to PWM
key_idx  output  KW  current target keyframe index
busy  output  1  high in RAMP or HOLD
arrive  output  1  one-cycle pulse when all channels reach the target

Behaviour:
- Reset: all outputs 0; state IDLE; keyframes 0; step_div 0; hold 0; last_key NUM_KEYS-1; divider count 0; hold count 0.
- Config writes take effect on the clock edge that samples cfg_we. Addresses outside 0..6 are ignored.
- Keyframe writes are legal mid-ramp. The new target applies from the next cycle.
- A step_div write clears the divider count.
- Tick: the divider count runs 0..step_div only in RAMP/HOLD. tick=1 in the cycle count==step_div, and the count returns to 0 on that cycle. Tick period = step_div+1 cycles; step_div=0 gives a tick every cycle. The count clears whenever the state is IDLE.
- Effective run: run_eff = run & ~manual_sel.
- IDLE:
  - busy=0; levels held.
  - If run_eff=1, go to RAMP next edge, keeping key_idx.
- RAMP:
  - On each tick, each channel independently moves ±1 toward keyframe[key_idx]. A channel equal to its target is unchanged.
  - No overflow or wrap: 8-bit saturating by construction.
  - When all three levels equal the target (checked every cycle, including on entry): go to HOLD, pulse arrive for 1 cycle, load hold count = hold.
- HOLD:
  - On each tick: if hold count==0, advance; else decrement.
  - Advance: key_idx <= (key_idx >= last_key) ? 0 : key_idx+1; go to RAMP.
  - With hold=0, HOLD lasts exactly until the first tick.
- run_eff=0 in RAMP/HOLD: go to IDLE next edge. Levels are frozen and key_idx retained, so resume continues toward the same key. arrive cannot pulse in that cycle.
- manual_sel=1: level_* <= manual_* every cycle (1-cycle latency). Sequencer levels are not updated.
- On manual_sel falling: the sequencer restarts its ramp from the currently output (manual) levels.
- last_key written below the current key_idx: the next advance wraps to 0.
- Reset asserted mid-operation: immediate return to reset values, including the keyframe table.
- Simultaneous cfg write to keyframe[key_idx] and arrival compare: the compare uses the old value that cycle.

Test Plan:
- Reset, write key0=0x102030, step_div=0, hold=2, last_key=0, run=1 -> arrive exactly once after 48 cycles in RAMP with levels 0x10/0x20/0x30; then HOLD 3 ticks, advance back to key0, re-arrive immediately (1-cycle RAMP).
- step_div=3, key0=0x020000, from levels 0 -> level_r 1 at the 4th RAMP cycle, 2 at the 8th, arrive in the same cycle level_r becomes 2.
- Keys 0..3 = 0xFF0000, 0x00FF00, 0x0000FF, 0x000000, last_key=3 -> key_idx sequence 0,1,2,3,0. Downward ramps reach 0 without wrap to 0xFF.
- Mid-ramp run=0 at level_r=0x40, wait 100 cycles, run=1 -> level_r stays 0x40 while idle, then resumes +1/tick. key_idx unchanged.
- manual_sel=1 with manual=0x112233 -> levels 0x11/0x22/0x33 one cycle later, busy=0. Release with key target 0x112235 -> arrive after 2 ticks.
- Assert reset during HOLD with key_idx=2 -> all outputs 0 same cycle (async), last_key=3, and run needs no re-config beyond keyframes.
